// File: rtl/axis_cplx_mag_pkg.sv
// Shared constants and width helpers for the complex-magnitude stage.
// Widths are derived from CHANNEL_WIDTH in each module. No types are shared.
package axis_cplx_mag_pkg;

    localparam int DEFAULT_NUM_CHANNELS  = 4;
    localparam int DEFAULT_CHANNEL_WIDTH = 32;

    // Each channel packs I in the low half and Q in the high half.
    function automatic int half_width(input int channel_width);
        return channel_width / 2;
    endfunction

endpackage

// File: rtl/cplx_mag_approx.sv
// One channel of the alpha-max-beta-min magnitude datapath, three register stages.
// Load enables come from the parent's valid/ready chain; this block has no control of its own.
module cplx_mag_approx #(
    parameter int HW = 16
) (
    input  logic          clk,
    input  logic          ld1,
    input  logic          ld2,
    input  logic          ld3,
    input  logic [HW-1:0] i_in,
    input  logic [HW-1:0] q_in,
    output logic [HW-1:0] mag
);

    localparam logic [HW-1:0] ONE = {{(HW-1){1'b0}}, 1'b1};

    logic [HW-1:0] a;
    logic [HW-1:0] b;
    logic [HW-1:0] mx;
    logic [HW-1:0] mn;

    // Unsigned result makes |-2^(HW-1)| = 2^(HW-1) exact without saturation.
    always_ff @(posedge clk) begin
        if (ld1) begin
            a <= i_in[HW-1] ? (~i_in + ONE) : i_in;
            b <= q_in[HW-1] ? (~q_in + ONE) : q_in;
        end
    end

    always_ff @(posedge clk) begin
        if (ld2) begin
            if (a >= b) begin
                mx <= a;
                mn <= b;
            end else begin
                mx <= b;
                mn <= a;
            end
        end
    end

    // beta = 3/8 via truncating shifts; peak 1.375*2^(HW-1) still fits in HW bits.
    always_ff @(posedge clk) begin
        if (ld3) begin
            mag <= mx + (mn >> 2) + (mn >> 3);
        end
    end

endmodule

// File: rtl/axis_cplx_mag.sv
// Multi-channel AXI-stream complex-magnitude stage: echoes tdata and adds a per-channel
// magnitude estimate, three pipeline stages with full per-stage backpressure.
module axis_cplx_mag
    import axis_cplx_mag_pkg::*;
#(
    parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
    parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   s_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   m_axis_tdata,
    output logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   m_axis_tdata_abs
);

    localparam int CW = CHANNEL_WIDTH;
    localparam int HW = half_width(CHANNEL_WIDTH);
    localparam int DW = CHANNEL_WIDTH * NUM_CHANNELS;

    // Handshake: a stage advances when it is empty or the stage after it advances.
    // A beat moves on tvalid & tready; s_axis_tready depends only on state and m_axis_tready.
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3 = ~v3 | m_axis_tready;
    assign adv2 = ~v2 | adv3;
    assign adv1 = ~v1 | adv2;

    assign s_axis_tready = adv1;
    assign m_axis_tvalid = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= s_axis_tvalid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // tdata rides the same load enables as the magnitude so the two stay beat-aligned.
    logic [DW-1:0] d1, d2, d3;

    always_ff @(posedge clk) begin
        if (adv1) d1 <= s_axis_tdata;
        if (adv2) d2 <= d1;
        if (adv3) d3 <= d2;
    end

    assign m_axis_tdata = d3;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        cplx_mag_approx #(
            .HW(HW)
        ) u_mag (
            .clk  (clk),
            .ld1  (adv1),
            .ld2  (adv2),
            .ld3  (adv3),
            .i_in (s_axis_tdata[c*CW +: HW]),
            .q_in (s_axis_tdata[c*CW+HW +: HW]),
            .mag  (m_axis_tdata_abs[c*CW +: HW])
        );
        assign m_axis_tdata_abs[c*CW+HW +: HW] = '0;
    end

endmodule

// File: tb/tb_axis_cplx_mag.sv
// Randomised scoreboard bench for axis_cplx_mag: driver pushes reference results on
// acceptance, monitor pops and compares on every output transfer.
module tb_axis_cplx_mag;

    localparam int NC = 4;
    localparam int CW = 32;
    localparam int HW = 16;
    localparam int DW = NC * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [DW-1:0] m_axis_tdata_abs;

    axis_cplx_mag #(
        .NUM_CHANNELS  (NC),
        .CHANNEL_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tdata_abs (m_axis_tdata_abs)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [2*DW-1:0] exp_q[$];
    int              cyc_q[$];
    int              n_cmp = 0;
    int              n_fail = 0;
    int              acc_cnt = 0;
    int              out_cnt = 0;
    bit              lat_chk = 1'b0;
    bit              stall_prev = 1'b0;
    logic [DW-1:0]   held_data;
    logic [DW-1:0]   held_abs;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: magnitude from plain integer arithmetic on the signed components.
    function automatic logic [DW-1:0] ref_abs(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int i, q, a, b, mx, mn, m;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            i = $signed(d[c*CW +: HW]);
            q = $signed(d[c*CW+HW +: HW]);
            a = (i < 0) ? -i : i;
            b = (q < 0) ? -q : q;
            mx = (a >= b) ? a : b;
            mn = (a >= b) ? b : a;
            m = mx + mn / 4 + mn / 8;
            r[c*CW +: HW] = m[HW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pack4(input int i0, q0, i1, q1, i2, q2, i3, q3);
        logic [DW-1:0] d;
        logic [HW-1:0] t [8];
        t[0] = i0[HW-1:0]; t[1] = q0[HW-1:0]; t[2] = i1[HW-1:0]; t[3] = q1[HW-1:0];
        t[4] = i2[HW-1:0]; t[5] = q2[HW-1:0]; t[6] = i3[HW-1:0]; t[7] = q3[HW-1:0];
        for (int k = 0; k < 8; k++) d[k*HW +: HW] = t[k];
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor / scoreboard (samples on the falling edge) ----------------
    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        int              c0;
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {{(DW-1){1'b0}}, m_axis_tvalid}, {{(DW-1){1'b0}}, 1'b1});
                check("hold_tdata", m_axis_tdata, held_data);
                check("hold_abs", m_axis_tdata_abs, held_abs);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata %0h, expected no beat", m_axis_tdata);
                end else begin
                    e  = exp_q.pop_front();
                    c0 = cyc_q.pop_front();
                    check("tdata", m_axis_tdata, e[DW-1:0]);
                    check("abs", m_axis_tdata_abs, e[2*DW-1:DW]);
                    if (lat_chk) check("latency", DW'(cyc - c0), DW'(3));
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cnt++;
                exp_q.push_back({ref_abs(s_axis_tdata), s_axis_tdata});
                cyc_q.push_back(cyc);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held_data  = m_axis_tdata;
            held_abs   = m_axis_tdata_abs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit rand_ready);
        int n;
        int budget;
        n = acc_cnt;
        budget = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        while (acc_cnt == n && budget < 200) begin
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
            step();
            budget++;
        end
        if (acc_cnt == n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles, expected acceptance", budget);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && k < budget) begin
            step();
            k++;
        end
        check("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        int a0, o0;

        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("reset_s_tready", DW'(s_axis_tready), DW'(1));

        // Directed corner beat: known magnitudes 512, 0, 45056, 32767.
        lat_chk = 1'b1;
        d = pack4(-300, 400, 0, 0, -32768, -32768, 32767, -1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        step();
        s_axis_tvalid = 1'b0;
        step();
        step();
        check("dir_valid", DW'(m_axis_tvalid), DW'(1));
        check("dir_abs_ch0", DW'(m_axis_tdata_abs[0*CW +: CW]), DW'(512));
        check("dir_abs_ch1", DW'(m_axis_tdata_abs[1*CW +: CW]), DW'(0));
        check("dir_abs_ch2", DW'(m_axis_tdata_abs[2*CW +: CW]), DW'(45056));
        check("dir_abs_ch3", DW'(m_axis_tdata_abs[3*CW +: CW]), DW'(32767));
        check("dir_echo", m_axis_tdata, d);
        drain(20);

        // 64-beat ramp with random downstream stalls.
        lat_chk = 1'b0;
        for (int k = 0; k < 64; k++) begin
            d = rand_beat();
            for (int c = 0; c < NC; c++) d[c*CW +: HW] = 16'(k * 1021 - 32768 + c * 4099);
            send(d, 1'b1);
        end
        drain(200);

        // Full pipe with downstream stalled, then a single-cycle release.
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_beat();
        for (int k = 0; k < 5; k++) begin
            a0 = acc_cnt;
            step();
            if (acc_cnt != a0) s_axis_tdata = rand_beat();
        end
        check("full_s_tready", DW'(s_axis_tready), DW'(0));
        check("full_m_tvalid", DW'(m_axis_tvalid), DW'(1));
        a0 = acc_cnt;
        o0 = out_cnt;
        m_axis_tready = 1'b1;
        #1;
        check("release_s_tready", DW'(s_axis_tready), DW'(1));
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        #1;
        check("release_one_in", DW'(acc_cnt - a0), DW'(1));
        check("release_one_out", DW'(out_cnt - o0), DW'(1));
        check("refull_s_tready", DW'(s_axis_tready), DW'(0));
        s_axis_tvalid = 1'b0;
        drain(50);

        // Reset with two beats in flight.
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_beat();
        step();
        s_axis_tdata  = rand_beat();
        step();
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        o0 = out_cnt;
        lat_chk = 1'b1;
        send(rand_beat(), 1'b0);
        drain(20);
        check("post_rst_out_count", DW'(out_cnt - o0), DW'(1));

        // Every-other-cycle input, downstream always ready.
        m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rand_beat();
            step();
            s_axis_tvalid = 1'b0;
            step();
        end
        drain(20);

        // Long idle: no spurious beats.
        o0 = out_cnt;
        repeat (10) step();
        check("idle_no_output", DW'(out_cnt - o0), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
